// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundles the WB-stage write request, the long-op result
// offer, the register-file write port and the hazard query/hit pair of the
// register-file write-port arbiter. "master" is the pipeline/long-op/hazard
// side, "slave" is the arbiter itself.
interface wb_port_arbiter_if #(
    parameter int LEN_WORD     = 32,
    parameter int LEN_REG_ADDR = 5
);
    // WB stage source
    logic                    wb_reg_write;
    logic [LEN_REG_ADDR-1:0] wb_write_reg;
    logic [LEN_WORD-1:0]     wb_write_data;
    logic                    wb_ready;

    // Long-op unit source
    logic                    lop_valid;
    logic [LEN_REG_ADDR-1:0] lop_write_reg;
    logic [LEN_WORD-1:0]     lop_write_data;
    logic                    lop_ready;

    // Register-file write port
    logic                    rf_reg_write;
    logic [LEN_REG_ADDR-1:0] rf_write_reg;
    logic [LEN_WORD-1:0]     rf_write_data;

    // Hazard unit query
    logic [LEN_REG_ADDR-1:0] query_rs;
    logic [LEN_REG_ADDR-1:0] query_rt;
    logic                    pend_hit_rs;
    logic                    pend_hit_rt;

    modport master (
        output wb_reg_write, wb_write_reg, wb_write_data,
        output lop_valid, lop_write_reg, lop_write_data,
        output query_rs, query_rt,
        input  wb_ready, lop_ready,
        input  rf_reg_write, rf_write_reg, rf_write_data,
        input  pend_hit_rs, pend_hit_rt
    );

    modport slave (
        input  wb_reg_write, wb_write_reg, wb_write_data,
        input  lop_valid, lop_write_reg, lop_write_data,
        input  query_rs, query_rt,
        output wb_ready, lop_ready,
        output rf_reg_write, rf_write_reg, rf_write_data,
        output pend_hit_rs, pend_hit_rt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order WB stage (zero-latency pass-through) and the long-op unit, whose
// results wait in a small circular buffer and drain into idle WB cycles.
// A per-head wait counter forces a one-cycle WB hold once a live head has
// waited MAX_WAIT cycles. A granted WB write kills older buffered results to
// the same register, and live buffered destinations are reported to the
// hazard unit.
//
// Optional feature: define WB_ARB_BYPASS_EN to let a long-op result go
// straight to the register file when the buffer is empty and WB is idle.
module wb_port_arbiter #(
    parameter int LEN_WORD     = 32,
    parameter int LEN_REG_ADDR = 5,
    parameter int DEPTH        = 2,
    parameter int MAX_WAIT     = 4
) (
    input logic               clk,
    input logic               rst_n,
    wb_port_arbiter_if.slave  bus
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FORCE} state_t;

    // Registered state
    state_t                  state;
    logic [DEPTH-1:0]        live_q;
    logic [LEN_REG_ADDR-1:0] addr_q [DEPTH];
    logic [LEN_WORD-1:0]     data_q [DEPTH];
    ptr_t                    head_q;
    ptr_t                    tail_q;
    logic [CNT_W-1:0]        count_q;
    logic [WAIT_W-1:0]       wait_q;

    // Next-state values
    state_t                  state_n;
    logic [DEPTH-1:0]        live_n;
    ptr_t                    head_n;
    ptr_t                    tail_n;
    logic [CNT_W-1:0]        count_n;
    logic [WAIT_W-1:0]       wait_n;

    // Arbitration terms
    logic empty;
    logic head_live;
    logic force_port;
    logic grant_wb;
    logic grant_head;
    logic bypass;
    logic push;
    logic pop;
    logic kill;

    // Output drivers
    logic                    rf_we;
    logic [LEN_REG_ADDR-1:0] rf_addr;
    logic [LEN_WORD-1:0]     rf_data;
    logic                    hit_rs;
    logic                    hit_rt;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty      = (count_q == '0);
    assign head_live  = !empty && live_q[head_q];
    assign force_port = (state == ST_FORCE);
    assign grant_wb   = bus.wb_reg_write && !force_port;
    assign grant_head = force_port || (!bus.wb_reg_write && head_live);

`ifdef WB_ARB_BYPASS_EN
    assign bypass = empty && !bus.wb_reg_write && bus.lop_valid;
`else
    assign bypass = 1'b0;
`endif

    // A full buffer stays not-ready even if it pops this cycle: lop_ready
    // depends only on registered occupancy.
    assign bus.lop_ready = (count_q < CNT_W'(DEPTH));
    assign push          = bus.lop_valid && bus.lop_ready && !bypass;
    // A dead head leaves without using the port, so it can pop under a WB grant.
    assign pop           = !empty && (grant_head || !live_q[head_q]);
    assign kill          = grant_wb && (bus.wb_write_reg != '0);

    assign bus.wb_ready      = !force_port;
    assign bus.rf_reg_write  = rf_we;
    assign bus.rf_write_reg  = rf_addr;
    assign bus.rf_write_data = rf_data;
    assign bus.pend_hit_rs   = hit_rs;
    assign bus.pend_hit_rt   = hit_rt;

    // Select the write-port source: forced head, WB, drainable head, bypass.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        if (grant_head) begin
            rf_we   = (addr_q[head_q] != '0);
            rf_addr = addr_q[head_q];
            rf_data = data_q[head_q];
        end else if (grant_wb) begin
            rf_we   = (bus.wb_write_reg != '0);
            rf_addr = bus.wb_write_reg;
            rf_data = bus.wb_write_data;
        end else if (bypass) begin
            rf_we   = (bus.lop_write_reg != '0);
            rf_addr = bus.lop_write_reg;
            rf_data = bus.lop_write_data;
        end
    end

    // Hazard hits over live buffered entries only (incoming result excluded).
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && addr_q[i] == bus.query_rs && bus.query_rs != '0)
                hit_rs = 1'b1;
            if (live_q[i] && addr_q[i] == bus.query_rt && bus.query_rt != '0)
                hit_rt = 1'b1;
        end
    end

    // Buffer bookkeeping after kill, pop and push, then the FSM decision.
    always_comb begin
        live_n = live_q;
        if (kill) begin
            for (int i = 0; i < DEPTH; i++)
                if (addr_q[i] == bus.wb_write_reg)
                    live_n[i] = 1'b0;
        end
        if (pop)
            live_n[head_q] = 1'b0;
        // Applied after the kill so an entry pushed this cycle survives it.
        if (push)
            live_n[tail_q] = (bus.lop_write_reg != '0);

        head_n = pop  ? ptr_inc(head_q) : head_q;
        tail_n = push ? ptr_inc(tail_q) : tail_q;

        unique case ({push, pop})
            2'b10:   count_n = count_q + CNT_W'(1);
            2'b01:   count_n = count_q - CNT_W'(1);
            default: count_n = count_q;
        endcase

        if (pop || count_n == '0)
            wait_n = '0;
        else if (head_live && !grant_head && wait_q != WAIT_W'(MAX_WAIT))
            wait_n = wait_q + WAIT_W'(1);
        else
            wait_n = wait_q;

        if (count_n == '0)
            state_n = ST_IDLE;
        else if (live_n[head_n] && wait_n == WAIT_W'(MAX_WAIT))
            state_n = ST_FORCE;
        else
            state_n = ST_PEND;
    end

    // FSM and buffer control state; reset discards every queued result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (!rst_n) begin
            state   <= ST_IDLE;
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            state   <= state_n;
            live_q  <= live_n;
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            wait_q  <= wait_n;
        end
    end

    // Buffer payload storage, written on push.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is not reset; live_q and count_q already mark
        // every slot invalid, so stale address/data can never be observed.
        if (push) begin
            addr_q[tail_q] <= bus.lop_write_reg;
            data_q[tail_q] <= bus.lop_write_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboarded bench for wb_port_arbiter (DEPTH=2,
// MAX_WAIT=4). Each task queues the register-file writes it expects and checks
// handshake/hazard outputs inline; a negedge monitor pops and compares every
// write the DUT performs. Honours WB_ARB_BYPASS_EN when defined.
module tb_wb_port_arbiter;

    localparam int LW = 32;
    localparam int LA = 5;

    typedef struct packed {
        logic [LA-1:0] reg_addr;
        logic [LW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.LEN_WORD(LW), .LEN_REG_ADDR(LA)) bus ();

    wb_port_arbiter #(
        .LEN_WORD    (LW),
        .LEN_REG_ADDR(LA),
        .DEPTH       (2),
        .MAX_WAIT    (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    wr_t exp_q [$];
    int  vectors     = 0;
    int  miscompares = 0;

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.rf_reg_write === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write: got reg %0d data %h, none expected",
                         bus.rf_write_reg, bus.rf_write_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rf_write_reg, bus.rf_write_data} !== e) begin
                    miscompares++;
                    $display("FAIL sb_write: got reg %0d data %h, want reg %0d data %h",
                             bus.rf_write_reg, bus.rf_write_data, e.reg_addr, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic ww, input logic [LA-1:0] wr, input logic [LW-1:0] wd,
                         input logic lv, input logic [LA-1:0] lr, input logic [LW-1:0] ld);
        bus.wb_reg_write   = ww;
        bus.wb_write_reg   = wr;
        bus.wb_write_data  = wd;
        bus.lop_valid      = lv;
        bus.lop_write_reg  = lr;
        bus.lop_write_data = ld;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [LA-1:0] r, input logic [LW-1:0] d);
        exp_q.push_back('{reg_addr: r, data: d});
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({bus.rf_reg_write, bus.wb_ready, bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt} !== 5'b01100) begin
            miscompares++;
            $display("FAIL reset_outputs: got we/wbr/lopr/hrs/hrt %b, want 01100",
                     {bus.rf_reg_write, bus.wb_ready, bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        next_cycle();
        drive(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0);
        expect_write(5'd5, 32'hA5);
        @(negedge clk);
        vectors++;
        if ({bus.wb_ready, bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 1'b1, 5'd5, 32'hA5}) begin
            miscompares++;
            $display("FAIL pass_through: got wbr %b we %b reg %0d data %h, want 1 1 5 a5",
                     bus.wb_ready, bus.rf_reg_write, bus.rf_write_reg, bus.rf_write_data);
        end
        next_cycle();
        drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++;
        if ({bus.wb_ready, bus.rf_reg_write} !== 2'b10) begin
            miscompares++;
            $display("FAIL pass_zero_reg: got wbr %b we %b, want 1 0", bus.wb_ready, bus.rf_reg_write);
        end
    endtask

    task automatic test_drain_full();
        next_cycle();
        bus.query_rs = 5'd8;
        bus.query_rt = 5'd9;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h1234);
        expect_write(5'd1, 32'h11);
        @(negedge clk);
        vectors++;
        if (bus.lop_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_ready_empty: got %b want 1", bus.lop_ready);
        end
        next_cycle();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h55);
        expect_write(5'd2, 32'h22);
        @(negedge clk);
        vectors++;
        if ({bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt} !== 3'b110) begin
            miscompares++;
            $display("FAIL drain_one_queued: got lopr/hrs/hrt %b want 110",
                     {bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt});
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_write(5'd8, 32'h1234);
        @(negedge clk);
        vectors++;
        if ({bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt, bus.rf_reg_write} !== 4'b0111) begin
            miscompares++;
            $display("FAIL drain_full: got lopr/hrs/hrt/we %b want 0111",
                     {bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt, bus.rf_reg_write});
        end
        next_cycle();
        expect_write(5'd9, 32'h55);
        @(negedge clk);
        vectors++;
        if ({bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt, bus.rf_reg_write} !== 4'b1011) begin
            miscompares++;
            $display("FAIL drain_second: got lopr/hrs/hrt/we %b want 1011",
                     {bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt, bus.rf_reg_write});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({bus.pend_hit_rt, bus.rf_reg_write} !== 2'b00) begin
            miscompares++;
            $display("FAIL drain_done: got hrt/we %b want 00", {bus.pend_hit_rt, bus.rf_reg_write});
        end
    endtask

    task automatic test_starvation();
        next_cycle();
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h77);
        expect_write(5'd1, 32'h100);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            drive(1'b1, LA'(10 + i), LW'(i), 1'b0, 5'd0, 32'h0);
            expect_write(LA'(10 + i), LW'(i));
            @(negedge clk);
            vectors++;
            if (bus.wb_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL starve_wb_cycle%0d: got wb_ready %b want 1", i, bus.wb_ready);
            end
        end
        next_cycle();
        drive(1'b1, 5'd20, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        expect_write(5'd3, 32'h77);
        @(negedge clk);
        vectors++;
        if ({bus.wb_ready, bus.rf_reg_write, bus.rf_write_reg} !== {1'b0, 1'b1, 5'd3}) begin
            miscompares++;
            $display("FAIL starve_force: got wbr %b we %b reg %0d, want 0 1 3",
                     bus.wb_ready, bus.rf_reg_write, bus.rf_write_reg);
        end
        next_cycle();
        expect_write(5'd20, 32'hDEAD);
        @(negedge clk);
        vectors++;
        if (bus.wb_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL starve_release: got wb_ready %b want 1", bus.wb_ready);
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus.rf_reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_empty: got we %b want 0", bus.rf_reg_write);
        end
    endtask

    task automatic test_waw_kill();
        next_cycle();
        bus.query_rs = 5'd9;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hAA);
        expect_write(5'd1, 32'h1);
        next_cycle();
        drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'h0);
        expect_write(5'd9, 32'hBB);
        @(negedge clk);
        vectors++;
        if (bus.pend_hit_rs !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_hit_before: got %b want 1", bus.pend_hit_rs);
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++;
        if ({bus.pend_hit_rs, bus.rf_reg_write} !== 2'b00) begin
            miscompares++;
            $display("FAIL waw_killed: got hrs/we %b want 00", {bus.pend_hit_rs, bus.rf_reg_write});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.rf_reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_no_stale: got we %b want 0", bus.rf_reg_write);
        end
        // Same-cycle push to the WB destination must survive.
        next_cycle();
        bus.query_rs = 5'd7;
        drive(1'b1, 5'd7, 32'h7, 1'b1, 5'd7, 32'h70);
        expect_write(5'd7, 32'h7);
        @(negedge clk);
        vectors++;
        if (bus.pend_hit_rs !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_incoming_excluded: got %b want 0", bus.pend_hit_rs);
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_write(5'd7, 32'h70);
        @(negedge clk);
        vectors++;
        if ({bus.pend_hit_rs, bus.rf_reg_write} !== 2'b11) begin
            miscompares++;
            $display("FAIL waw_same_cycle_survives: got hrs/we %b want 11", {bus.pend_hit_rs, bus.rf_reg_write});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.pend_hit_rs !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_hit_after_pop: got %b want 0", bus.pend_hit_rs);
        end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        bus.query_rs = 5'd0;
        bus.query_rt = 5'd0;
        drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd0, 32'h99);
        expect_write(5'd1, 32'h2);
        @(negedge clk);
        vectors++;
        if (bus.lop_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_accept: got lop_ready %b want 1", bus.lop_ready);
        end
        next_cycle();
        drive(1'b1, 5'd2, 32'h3, 1'b1, 5'd4, 32'h44);
        expect_write(5'd2, 32'h3);
        @(negedge clk);
        vectors++;
        if ({bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt} !== 3'b100) begin
            miscompares++;
            $display("FAIL zero_dead_head: got lopr/hrs/hrt %b want 100",
                     {bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt});
        end
        // The dead head popped alongside the WB grant, so one slot is free.
        next_cycle();
        drive(1'b1, 5'd3, 32'h4, 1'b1, 5'd6, 32'h66);
        expect_write(5'd3, 32'h4);
        @(negedge clk);
        vectors++;
        if (bus.lop_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_dead_pop_with_wb: got lop_ready %b want 1", bus.lop_ready);
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_write(5'd4, 32'h44);
        next_cycle();
        expect_write(5'd6, 32'h66);
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.rf_reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_drained: got we %b want 0", bus.rf_reg_write);
        end
    endtask

    task automatic test_lop_latency();
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB0B);
`ifdef WB_ARB_BYPASS_EN
        expect_write(5'd11, 32'hB0B);
        @(negedge clk);
        vectors++;
        if ({bus.rf_reg_write, bus.lop_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got we/lopr %b want 11", {bus.rf_reg_write, bus.lop_ready});
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus.rf_reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_not_pushed: got we %b want 0", bus.rf_reg_write);
        end
`else
        @(negedge clk);
        vectors++;
        if ({bus.rf_reg_write, bus.lop_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL lop_latency_cycle0: got we/lopr %b want 01", {bus.rf_reg_write, bus.lop_ready});
        end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_write(5'd11, 32'hB0B);
        @(negedge clk);
        vectors++;
        if (bus.rf_reg_write !== 1'b1) begin
            miscompares++;
            $display("FAIL lop_latency_cycle1: got we %b want 1", bus.rf_reg_write);
        end
`endif
    endtask

    task automatic test_reset_mid_drain();
        next_cycle();
        bus.query_rs = 5'd8;
        bus.query_rt = 5'd9;
        drive(1'b1, 5'd1, 32'h5, 1'b1, 5'd8, 32'h31);
        expect_write(5'd1, 32'h5);
        next_cycle();
        drive(1'b1, 5'd2, 32'h6, 1'b1, 5'd9, 32'h32);
        expect_write(5'd2, 32'h6);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.rf_reg_write, bus.wb_ready, bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt} !== 5'b01100) begin
            miscompares++;
            $display("FAIL reset_mid_drain: got we/wbr/lopr/hrs/hrt %b want 01100",
                     {bus.rf_reg_write, bus.wb_ready, bus.lop_ready, bus.pend_hit_rs, bus.pend_hit_rt});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            vectors++;
            if ({bus.rf_reg_write, bus.pend_hit_rs, bus.pend_hit_rt} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_no_stale%0d: got we/hrs/hrt %b want 000",
                         i, {bus.rf_reg_write, bus.pend_hit_rs, bus.pend_hit_rt});
            end
        end
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.query_rs = 5'd0;
        bus.query_rt = 5'd0;

        test_reset();
        test_pass_through();
        test_drain_full();
        test_starvation();
        test_waw_kill();
        test_zero_reg();
        test_lop_latency();
        test_reset_mid_drain();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d writes never performed, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline WB stage and the multi-cycle long-op unit (mult/div results).
- Pipeline writes pass through with zero latency. Long-op results are queued in a small buffer and drained into idle WB cycles.
- A starvation counter forces a one-cycle WB hold so a queued result cannot wait forever.
- Exposes pending-destination hits to the hazard unit.

Parameters:
- LEN_WORD, 32, data width.
- LEN_REG_ADDR, 5, register address width.
- DEPTH, 2, long-op buffer entries (>=1).
- MAX_WAIT, 4, cycles a live head entry may wait before forcing the port (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_reg_write  in  1  WB stage requests a write.
- wb_write_reg  in  LEN_REG_ADDR  WB destination.
- wb_write_data  in  LEN_WORD  WB data.
- wb_ready  out  1  WB write granted this cycle; 0 means the pipeline must hold WB.
- lop_valid  in  1  long-op result offered.
- lop_write_reg  in  LEN_REG_ADDR  long-op destination.
- lop_write_data  in  LEN_WORD  long-op data.
- lop_ready  out  1  buffer can accept this cycle.
- rf_reg_write  out  1  register-file write enable.
- rf_write_reg  out  LEN_REG_ADDR  register-file write address.
- rf_write_data  out  LEN_WORD  register-file write data.
- query_rs  in  LEN_REG_ADDR  hazard query address.
- query_rt  in  LEN_REG_ADDR  hazard query address.
- pend_hit_rs  out  1  live buffered entry matches query_rs.
- pend_hit_rt  out  1  live buffered entry matches query_rt.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer empty, all entries dead, wait_cnt=0, state IDLE.
  - Outputs: rf_reg_write=0, wb_ready=1, lop_ready=1, pend_hit_*=0.
  - Reset mid-drain discards all queued results.
- Buffer:
  - Circular FIFO of {live, addr, data}.
  - lop_ready = (count < DEPTH), registered-state based, combinational output.
  - Push on lop_valid && lop_ready. An entry with addr 0 is pushed dead.
  - Full plus a simultaneous pop the same cycle does NOT raise lop_ready that cycle.
- FSM:
  - IDLE: buffer empty.
  - PEND: head present, wait_cnt < MAX_WAIT.
  - FORCE: head live and wait_cnt == MAX_WAIT.
  - Transitions are evaluated after push/pop each edge.
- Grant, combinational, in priority order:
  - (a) FORCE: port to head, wb_ready=0.
  - (b) wb_reg_write=1: port to WB, wb_ready=1.
  - (c) Head live: port to head.
  - (d) Otherwise no write.
  - wb_ready=1 in all cases except FORCE.
- rf outputs:
  - rf_reg_write = granted && address != 0.
  - rf_write_reg / rf_write_data are taken from the granted source.
  - With no grant, rf_write_reg=0 and rf_write_data=0.
- Pop:
  - The head pops when granted.
  - A dead head pops in any cycle without using the port, so it may coincide with a WB grant.
- wait_cnt:
  - Cleared on pop or empty.
  - Increments while the head is live and not granted; saturates at MAX_WAIT.
- WAW kill:
  - A granted WB write to addr A≠0 clears live on every buffered entry with addr A.
  - Applies to entries present before the edge; an entry pushed the same cycle is not killed.
  - A killed head drops to PEND/IDLE and is popped without writing.
- Hazard query:
  - pend_hit_x = 1 if any live buffered entry has addr == query_x and query_x≠0.
  - Combinational from registered state; the incoming lop is not included.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- With the macro defined: in a cycle with the buffer empty, wb_reg_write=0 and lop_valid=1, the lop result is written to the register file in the same cycle and is not pushed. lop_ready stays 1.
- Without the macro: every lop result goes through the buffer, so the minimum lop-to-RF latency is 1 cycle.

Test Plan:
- Reset: assert rst_n=0 mid-drain with 2 entries queued -> immediately rf_reg_write=0, lop_ready=1, wb_ready=1, pend_hit_*=0; after release, no stale write occurs.
- Pass-through: wb_reg_write=1, reg 5, data 0xA5 -> same cycle rf_reg_write=1, reg 5, data 0xA5, wb_ready=1.
- Drain and full:
  - Setup: wb busy, push (8,0x1234) and (9,0x55) -> lop_ready=0.
  - Then drop wb_reg_write -> RF writes reg 8 then reg 9 on consecutive cycles, lop_ready=1 after the first pop, pend_hit on 8 clears after its pop.
- Starvation (MAX_WAIT=4): wb_reg_write held 1, one entry (3,0x77) queued -> WB granted for 4 cycles, 5th cycle wb_ready=0 and RF writes reg 3 with 0x77, 6th cycle wb_ready=1.
- WAW kill: buffer holds (9,0xAA), WB writes reg 9 with 0xBB -> RF writes 0xBB, entry killed, pend_hit_rs (query 9) low next cycle, 0xAA never written.
- Zero register: lop push to reg 0 -> accepted, never produces rf_reg_write, pend_hit for query 0 stays 0.
